// File: rtl/proc_sequencer_pkg.sv
// Shared processor package: opcode definitions, sequencer state encoding,
// and the opcode field location inside a 16-bit instruction word.
// Imported by the sequencer top and its watchdog.
package proc_sequencer_pkg;

    // Opcode field position within the 16-bit instruction word
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;

    // Processor opcodes; OP_HALT doubles as the default program terminator
    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_MOVI  = 3'b101,
        OP_JMP   = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    localparam logic [2:0] HALT_OP_DEF = OP_HALT;

    // Sequencer FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_PAUSE  = 3'd5,
        ST_HALTED = 3'd6,
        ST_ERROR  = 3'd7
    } seq_state_t;

    // Extract the opcode field from an instruction word
    function automatic logic [2:0] opcode_of(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/proc_sequencer_watchdog.sv
// Watchdog for the sequencer WAIT state: counts enabled cycles since the last
// clear and flags 'expired' combinationally on the TIMEOUT-th enabled cycle.
// Ports: clock/Resetn, clear (sync zero), enable (count this cycle), expired.
module seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic Resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Counter only has to reach TIMEOUT-1; expiry is detected on the cycle
    // that would make it TIMEOUT, so the caller leaves WAIT on that edge.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == LAST);
    assign expired = enable && at_last;

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !at_last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches words from a synchronous ROM, issues each to a
// processor with a one-cycle run strobe, waits for done, and stops on a HALT
// opcode, on a watchdog timeout, or (in step mode) after every instruction.
// Ports: clock/Resetn; start, step_mode, step controls; rom_addr/rom_data ROM
// port; iin/run/done processor handshake; pc, instr_count, busy, halted, error.
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [2:0] HALT_OP = HALT_OP_DEF,
    parameter int         TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              Resetn,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       iin,
    output logic              run,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count,
    output logic              busy,
    output logic              halted,
    output logic              error
);

    seq_state_t state, state_nxt;

    // Control strobes from the FSM to the datapath registers
    logic restart;      // clear pc and instr_count on (re)start
    logic ir_load;      // capture rom_data into the instruction register
    logic retire;       // done accepted: advance pc, bump instr_count
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    logic is_halt_word;

    // The ROM address is the pc itself: pc only changes on restart or retire,
    // so it is already stable when FETCH presents it and reads back as 0 in
    // reset.
    assign rom_addr     = pc;
    assign is_halt_word = (opcode_of(rom_data) == HALT_OP);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        restart   = 1'b0;
        ir_load   = 1'b0;
        retire    = 1'b0;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        error     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy      = 1'b1;
                state_nxt = ST_LOAD;
            end

            // rom_data now reflects the address presented in FETCH. A HALT
            // word is still captured but never issued, and pc stays on it.
            ST_LOAD: begin
                busy      = 1'b1;
                ir_load   = 1'b1;
                state_nxt = is_halt_word ? ST_HALTED : ST_ISSUE;
            end

            ST_ISSUE: begin
                busy      = 1'b1;
                run       = 1'b1;
                wd_clear  = 1'b1;
                state_nxt = ST_WAIT;
            end

            // done wins over a same-cycle timeout: the instruction did finish.
            ST_WAIT: begin
                busy = 1'b1;
                if (done) begin
                    retire    = 1'b1;
                    state_nxt = step_mode ? ST_PAUSE : ST_FETCH;
                end else begin
                    wd_enable = 1'b1;
                    if (wd_expired) begin
                        state_nxt = ST_ERROR;
                    end
                end
            end

            // Leaving step mode while paused resumes free-running execution.
            ST_PAUSE: begin
                if (step || !step_mode) begin
                    state_nxt = ST_FETCH;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_ERROR: begin
                error = 1'b1;
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: program counter, retired count, instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            pc <= '0;
        end else if (restart) begin
            pc <= '0;
        end else if (retire) begin
            // Natural modulo-2^ADDR_W wrap; execution simply continues at 0.
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            instr_count <= '0;
        end else if (restart) begin
            instr_count <= '0;
        end else if (retire && (instr_count != 16'hFFFF)) begin
            instr_count <= instr_count + 16'd1;
        end
    end

    // iin is only written in LOAD, so it holds from ISSUE until the next LOAD.
    always_ff @(posedge clock or negedge Resetn) begin
        if (!Resetn) begin
            iin <= '0;
        end else if (ir_load) begin
            iin <= rom_data;
        end
    end

    // ------------------------------------------------------------------
    // WAIT-state timeout
    // ------------------------------------------------------------------
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .Resetn  (Resetn),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, instruction ROM address width.
REQ-002 Parameter HALT_OP, default 3'b111, opcode value in iin[15:13] that terminates the program.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before the error state.
REQ-004 The port list SHALL be:
  clock  in  1  single clock, all state on rising edge.
  Resetn  in  1  asynchronous, active-low reset.
  start  in  1  level, begins/restarts execution from address 0.
  step_mode  in  1  1 = pause after each instruction.
  step  in  1  one-cycle pulse, releases one paused instruction.
  rom_addr  out  ADDR_W  instruction ROM read address.
  rom_data  in  16  ROM read data, valid one cycle after rom_addr (synchronous ROM).
  iin  out  16  instruction word to processor.
  run  out  1  one-cycle issue strobe to processor.
  done  in  1  processor completion pulse.
  pc  out  ADDR_W  address of current instruction.
  instr_count  out  16  retired-instruction count.
  busy  out  1  high in FETCH, LOAD, ISSUE, WAIT.
  halted  out  1  high in HALTED.
  error  out  1  high in ERROR.

Function
REQ-005 The FSM SHALL have states IDLE, FETCH, LOAD, ISSUE, WAIT, PAUSE, HALTED, ERROR.
REQ-006 IDLE: start=1 -> FETCH, with pc and instr_count cleared to 0.
REQ-007 FETCH: rom_addr SHALL equal pc; next state LOAD unconditionally.
REQ-008 LOAD: rom_data SHALL be captured into the instruction register driving iin; rom_data[15:13]==HALT_OP -> HALTED, else -> ISSUE.
REQ-009 ISSUE: run SHALL be 1 for exactly this one cycle; next state WAIT; the timeout counter is cleared.
REQ-010 iin SHALL hold stable from ISSUE until the next LOAD; run SHALL be 0 in every other state.
REQ-011 done SHALL be sampled only in WAIT; a done pulse in any other state is ignored.
REQ-012 WAIT with done=1: pc <= pc+1 (wrapping from 2^ADDR_W-1 to 0); instr_count <= instr_count+1, saturating at 0xFFFF; next state is PAUSE if step_mode=1, else FETCH.
REQ-013 WAIT with done=0: the timeout counter increments; reaching TIMEOUT -> ERROR, pc and instr_count unchanged.
REQ-014 PAUSE: step=1 -> FETCH; otherwise remain; step_mode dropping to 0 while in PAUSE -> FETCH.
REQ-015 HALTED and ERROR SHALL be sticky; start=1 -> FETCH with pc and instr_count cleared (restart).
REQ-016 start SHALL be ignored in FETCH, LOAD, ISSUE, WAIT, PAUSE.
REQ-017 A HALT word SHALL NOT be issued: run stays 0, pc stays at the HALT address, and instr_count is unchanged.
REQ-018 The pc wrap condition SHALL raise no flag; execution continues at address 0.

Reset
REQ-019 Resetn=0 SHALL, asynchronously and at any state, force IDLE, pc=0, instr_count=0, iin=0, run=0, rom_addr=0, busy=0, halted=0, error=0, timeout counter=0.
REQ-020 An in-flight instruction at reset SHALL be abandoned; a later done SHALL NOT retire it.
REQ-021 Operation SHALL resume only on start=1 after Resetn returns high.

Structure
REQ-022 State encoding, HALT_OP default, and the opcode field position [15:13] SHALL live in the shared processor package alongside the processor opcode definitions.
REQ-023 The timeout counter SHALL be one sub-module, seq_watchdog (clear, enable, expired), and the remainder is flat.

Verification
REQ-024 ROM = {0xA01C, 0xA40A, 0x2080, 0xE000}, done returned 3 cycles after each run, step_mode=0, start pulse -> 3 run pulses with iin = 0xA01C, 0xA40A, 0x2080 in order; halted=1, pc=3, instr_count=3, run never high for 0xE000.
REQ-025 Same ROM, step_mode=1 -> after the first done, state PAUSE with busy=0 and pc=1; no run until a step pulse; the step pulse produces a run 3 cycles later (FETCH, LOAD, ISSUE).
REQ-026 done withheld after the first run, TIMEOUT=255 -> error=1 exactly 255 cycles after entering WAIT, pc=0, instr_count=0; a subsequent start restarts at address 0.
REQ-027 Resetn pulled low in the WAIT of the second instruction, then released, with a stray done delivered -> all outputs at reset values, instr_count=0, state IDLE.
REQ-028 ADDR_W=2 with a ROM of 4 non-halt words looping -> pc sequence 0,1,2,3,0,1; instr_count keeps incrementing; a done pulse injected during FETCH does not advance pc.
